fmlarb4: RTL and testbench
==========================

FMLARB4 -- requirements
Module: fmlarb4

Interface
REQ-001 Parameter: sdram_depth, default 26, FML byte-address width; same value as on the memory controller it feeds.
REQ-002 sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 sys_rst  in  1  reset, asynchronous, active-high.
REQ-004 mN_adr  in  sdram_depth  master N address, N = 0..3.
REQ-005 mN_stb  in  1  master N request, held until its mN_ack.
REQ-006 mN_we  in  1  master N write (1) / read (0).
REQ-007 mN_sel  in  8  master N byte enables, per write beat.
REQ-008 mN_di  in  64  master N write data, per write beat.
REQ-009 mN_ack  out  1  master N acknowledge.
REQ-010 mN_do  out  64  read data to master N.
REQ-011 s_adr  out  sdram_depth  address to the controller.
REQ-012 s_stb  out  1  request to the controller.
REQ-013 s_we  out  1  write/read to the controller.
REQ-014 s_ack  in  1  controller acknowledge.
REQ-015 s_sel  out  8  byte enables to the controller.
REQ-016 s_di  out  64  write data to the controller.
REQ-017 s_do  in  64  read data from the controller.

Function
REQ-018 Bursts are 4 beats of 64 bits; write beats are sampled by the controller in the s_ack cycle and the 3 following cycles; read beats arrive on s_do in the 4 cycles after s_ack.
REQ-019 States: IDLE, REQ, DATA; a 2-bit beat counter and a 2-bit grant register (gnt) are kept; last-served register (last) is 2 bits.
REQ-020 IDLE: if any mN_stb=1, gnt <= first requesting N in round-robin order last+1, last+2, last+3, last (mod 4); state -> REQ; otherwise stay IDLE.
REQ-021 REQ: s_stb = m[gnt]_stb; s_adr, s_we = m[gnt] values, combinational from gnt.
REQ-022 REQ: m[gnt]_ack = s_ack; every other mN_ack = 0; on s_ack=1: last <= gnt, counter <= 0, state -> DATA.
REQ-023 REQ: if m[gnt]_stb drops before s_ack (protocol violation), state -> IDLE, last unchanged, no ack issued.
REQ-024 DATA: s_stb = 0; counter increments each cycle; after 3 DATA cycles (counter = 2) state -> IDLE.
REQ-025 s_sel, s_di = m[gnt]_sel, m[gnt]_di in REQ and DATA; 0 in IDLE.
REQ-026 mN_do = s_do for every N, unconditionally (broadcast); masters track their own read timing.
REQ-027 s_stb and all mN_ack are 0 in IDLE and DATA.
REQ-028 Latency: mN_stb rising in IDLE -> s_stb at next cycle; minimum spacing between consecutive s_ack is 5 cycles.
REQ-029 Requests arriving in REQ or DATA are not considered until the next IDLE cycle; gnt never changes outside IDLE.
REQ-030 Simultaneous requests: exactly one grant per arbitration; no master is skipped more than 3 consecutive arbitrations while requesting.
REQ-031 Counter wraps modulo 4; it is not read outside DATA.

Reset
REQ-032 sys_rst=1 forces, asynchronously: state IDLE, counter 0, gnt 0, last 3 (master 0 has first priority); s_stb, s_we, s_sel, s_di, all mN_ack = 0.
REQ-033 Reset asserted in REQ or DATA aborts the burst; no ack is issued after release until a new arbitration.

Verification
REQ-034 Single write: m2_stb=1, m2_we=1, s_ack after 2 cycles in REQ -> s_stb 1 cycle after m2_stb, m2_ack high 1 cycle, s_di follows m2_di for 4 cycles from ack, return to IDLE.
REQ-035 All four stb held from reset -> grants in order 0,1,2,3,0 with s_ack gaps of 5 cycles when controller acks immediately.
REQ-036 m1 and m3 requesting with last=1 -> m3 granted, then m1.
REQ-037 Read by m0: s_do values A,B,C,D in 4 cycles after s_ack -> m0_do..m3_do all show A,B,C,D.
REQ-038 m2_stb dropped in REQ before s_ack -> s_stb falls, no m2_ack, last unchanged, next arbitration uses old priority.
REQ-039 sys_rst pulsed during DATA of m1 write -> outputs zero immediately; after release m0 (requesting) granted first.

Source files
------------

// File: rtl/fmlarb4.sv
// Four-master round-robin arbiter in front of an FML SDRAM controller.
// One 4-beat burst is owned at a time; read data is broadcast to every master.
module fmlarb4 #(
  parameter int sdram_depth = 26
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,

  input  logic [sdram_depth-1:0] m0_adr,
  input  logic                   m0_stb,
  input  logic                   m0_we,
  input  logic [7:0]             m0_sel,
  input  logic [63:0]            m0_di,
  output logic                   m0_ack,
  output logic [63:0]            m0_do,

  input  logic [sdram_depth-1:0] m1_adr,
  input  logic                   m1_stb,
  input  logic                   m1_we,
  input  logic [7:0]             m1_sel,
  input  logic [63:0]            m1_di,
  output logic                   m1_ack,
  output logic [63:0]            m1_do,

  input  logic [sdram_depth-1:0] m2_adr,
  input  logic                   m2_stb,
  input  logic                   m2_we,
  input  logic [7:0]             m2_sel,
  input  logic [63:0]            m2_di,
  output logic                   m2_ack,
  output logic [63:0]            m2_do,

  input  logic [sdram_depth-1:0] m3_adr,
  input  logic                   m3_stb,
  input  logic                   m3_we,
  input  logic [7:0]             m3_sel,
  input  logic [63:0]            m3_di,
  output logic                   m3_ack,
  output logic [63:0]            m3_do,

  output logic [sdram_depth-1:0] s_adr,
  output logic                   s_stb,
  output logic                   s_we,
  input  logic                   s_ack,
  output logic [7:0]             s_sel,
  output logic [63:0]            s_di,
  input  logic [63:0]            s_do
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] last_q, last_d;

  logic [sdram_depth-1:0] adr [4];
  logic [7:0]             sel [4];
  logic [63:0]            di  [4];
  logic [3:0]             stb, we, ack_v;
  logic                   in_req, in_xfer;

  assign adr = '{m0_adr, m1_adr, m2_adr, m3_adr};
  assign sel = '{m0_sel, m1_sel, m2_sel, m3_sel};
  assign di  = '{m0_di, m1_di, m2_di, m3_di};
  assign stb = {m3_stb, m2_stb, m1_stb, m0_stb};
  assign we  = {m3_we, m2_we, m1_we, m0_we};

  // Highest priority is last+1; scanning from lowest to highest lets the winner overwrite.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + k[1:0];
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|stb) begin
          gnt_d   = rr_pick(stb, last_q);
          state_d = REQ;
        end
      end
      REQ: begin
        // A withdrawn request abandons the grant without touching priority.
        if (!stb[gnt_q]) begin
          state_d = IDLE;
        end else if (s_ack) begin
          last_d  = gnt_q;
          cnt_d   = 2'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      gnt_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign in_req  = (state_q == REQ);
  assign in_xfer = in_req || (state_q == DATA);

  assign s_adr = adr[gnt_q];
  assign s_stb = in_req && stb[gnt_q];
  assign s_we  = in_req && we[gnt_q];
  assign s_sel = in_xfer ? sel[gnt_q] : 8'd0;
  assign s_di  = in_xfer ? di[gnt_q] : 64'd0;

  assign ack_v  = (in_req && stb[gnt_q] && s_ack) ? (4'b0001 << gnt_q) : 4'b0000;
  assign m0_ack = ack_v[0];
  assign m1_ack = ack_v[1];
  assign m2_ack = ack_v[2];
  assign m3_ack = ack_v[3];

  assign m0_do = s_do;
  assign m1_do = s_do;
  assign m2_do = s_do;
  assign m3_do = s_do;

endmodule

// File: tb/tb_fmlarb4.sv
// Directed bench for fmlarb4: burst handshakes, round-robin order, read broadcast,
// withdrawn requests and reset in mid-burst.
module tb_fmlarb4;
  localparam int AW = 26;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [AW-1:0] adr [4];
  logic [7:0]    sel [4];
  logic [63:0]   di  [4];
  logic [3:0]    stb, we;
  logic [3:0]    ack;
  logic [63:0]   mdo [4];
  logic [AW-1:0] s_adr;
  logic          s_stb, s_we, s_ack;
  logic [7:0]    s_sel;
  logic [63:0]   s_di, s_do;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_cyc  = 0;

  fmlarb4 #(.sdram_depth(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_adr(adr[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_sel(sel[0]), .m0_di(di[0]),
    .m0_ack(ack[0]), .m0_do(mdo[0]),
    .m1_adr(adr[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_sel(sel[1]), .m1_di(di[1]),
    .m1_ack(ack[1]), .m1_do(mdo[1]),
    .m2_adr(adr[2]), .m2_stb(stb[2]), .m2_we(we[2]), .m2_sel(sel[2]), .m2_di(di[2]),
    .m2_ack(ack[2]), .m2_do(mdo[2]),
    .m3_adr(adr[3]), .m3_stb(stb[3]), .m3_we(we[3]), .m3_sel(sel[3]), .m3_di(di[3]),
    .m3_ack(ack[3]), .m3_do(mdo[3]),
    .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_ack(s_ack),
    .s_sel(s_sel), .s_di(s_di), .s_do(s_do)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Entered in IDLE with requests set; leaves in IDLE after a full burst to master g.
  task automatic serve(input int g, input bit keep, input bit gapchk);
    step();
    chk("serve_stb", 64'(s_stb), 64'd1);
    chk("serve_adr", 64'(s_adr), 64'(adr[g]));
    s_ack = 1'b1;
    #1;
    chk("serve_ack", 64'(ack), 64'(4'b0001 << g));
    if (gapchk) chk("ack_gap", 64'(cyc - ack_cyc), 64'd5);
    ack_cyc = cyc;
    step();
    s_ack = 1'b0;
    if (!keep) stb[g] = 1'b0;
    #1;
    chk("data_ack", 64'(ack), 64'd0);
    chk("data_stb", 64'(s_stb), 64'd0);
    chk("data_sel", 64'(s_sel), 64'(sel[g]));
    step();
    step();
    step();
    chk("end_sel", 64'(s_sel), 64'd0);
  endtask

  initial begin
    sys_rst = 1'b1;
    stb = 4'b0;
    we = 4'b0;
    s_ack = 1'b0;
    s_do = 64'd0;
    for (int g = 0; g < 4; g++) begin
      adr[g] = AW'(32'h1000 * (g + 1));
      sel[g] = 8'h11 << g;
      di[g]  = 64'hA0A0_0000_0000_0000 | 64'(g);
    end
    step();
    step();
    chk("rst_stb", 64'(s_stb), 64'd0);
    chk("rst_we", 64'(s_we), 64'd0);
    chk("rst_sel", 64'(s_sel), 64'd0);
    chk("rst_di", 64'(s_di), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_gnt", 64'(s_adr), 64'(adr[0]));
    sys_rst = 1'b0;

    // Single write by m2 with the controller acking in the second REQ cycle
    step();
    stb[2] = 1'b1;
    we[2] = 1'b1;
    #1;
    chk("w_idle_stb", 64'(s_stb), 64'd0);
    step();
    chk("w_req_stb", 64'(s_stb), 64'd1);
    chk("w_req_we", 64'(s_we), 64'd1);
    chk("w_req_adr", 64'(s_adr), 64'(adr[2]));
    chk("w_req_ack", 64'(ack), 64'd0);
    step();
    chk("w_req2_stb", 64'(s_stb), 64'd1);
    s_ack = 1'b1;
    #1;
    chk("w_ack", 64'(ack), 64'b0100);
    chk("w_di0", 64'(s_di), 64'hA0A0_0000_0000_0002);
    chk("w_sel0", 64'(s_sel), 64'h44);
    step();
    s_ack = 1'b0;
    stb[2] = 1'b0;
    we[2] = 1'b0;
    di[2] = 64'hD1;
    #1;
    chk("w_di1", 64'(s_di), 64'hD1);
    chk("w_data_ack", 64'(ack), 64'd0);
    step();
    di[2] = 64'hD2;
    #1;
    chk("w_di2", 64'(s_di), 64'hD2);
    step();
    di[2] = 64'hD3;
    #1;
    chk("w_di3", 64'(s_di), 64'hD3);
    step();
    chk("w_idle_di", 64'(s_di), 64'd0);
    chk("w_idle_stb2", 64'(s_stb), 64'd0);

    // Read by m0: s_do broadcast to all masters
    stb[0] = 1'b1;
    step();
    s_ack = 1'b1;
    #1;
    chk("r_ack", 64'(ack), 64'b0001);
    chk("r_we", 64'(s_we), 64'd0);
    step();
    s_ack = 1'b0;
    stb[0] = 1'b0;
    s_do = 64'hAAAA_0001;
    #1;
    for (int n = 0; n < 4; n++) chk("r_do_a", mdo[n], 64'hAAAA_0001);
    step();
    s_do = 64'hBBBB_0002;
    #1;
    for (int n = 0; n < 4; n++) chk("r_do_b", mdo[n], 64'hBBBB_0002);
    step();
    s_do = 64'hCCCC_0003;
    #1;
    for (int n = 0; n < 4; n++) chk("r_do_c", mdo[n], 64'hCCCC_0003);
    step();
    s_do = 64'hDDDD_0004;
    #1;
    for (int n = 0; n < 4; n++) chk("r_do_d", mdo[n], 64'hDDDD_0004);

    // last=0 -> m1 alone, then m1+m3 with last=1 grants m3 before m1
    stb[1] = 1'b1;
    serve(1, 1'b0, 1'b0);
    stb[1] = 1'b1;
    stb[3] = 1'b1;
    serve(3, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b0);

    // m2 withdraws in REQ while the controller acks: no ack, priority unchanged (last=1)
    stb[2] = 1'b1;
    step();
    chk("drop_stb_before", 64'(s_stb), 64'd1);
    stb[2] = 1'b0;
    s_ack = 1'b1;
    #1;
    chk("drop_stb_after", 64'(s_stb), 64'd0);
    chk("drop_ack", 64'(ack), 64'd0);
    step();
    s_ack = 1'b0;
    #1;
    chk("drop_idle_stb", 64'(s_stb), 64'd0);
    stb[2] = 1'b1;
    stb[3] = 1'b1;
    serve(2, 1'b0, 1'b0);
    serve(3, 1'b0, 1'b0);

    // Controller ack while idle must not reach any master
    s_ack = 1'b1;
    #1;
    chk("idle_ack", 64'(ack), 64'd0);
    s_ack = 1'b0;

    // All four requesting from reset, immediate acks: 0,1,2,3,0 every 5 cycles
    sys_rst = 1'b1;
    stb = 4'b1111;
    step();
    step();
    sys_rst = 1'b0;
    #1;
    serve(0, 1'b1, 1'b0);
    serve(1, 1'b1, 1'b1);
    serve(2, 1'b1, 1'b1);
    serve(3, 1'b1, 1'b1);
    serve(0, 1'b1, 1'b1);

    // Reset during DATA of an m1 write aborts it; m0 wins afterwards
    we[1] = 1'b1;
    step();
    chk("rd_adr", 64'(s_adr), 64'(adr[1]));
    s_ack = 1'b1;
    #1;
    chk("rd_ack", 64'(ack), 64'b0010);
    step();
    s_ack = 1'b0;
    #1;
    chk("rd_sel_pre", 64'(s_sel), 64'h22);
    sys_rst = 1'b1;
    #1;
    chk("rd_sel", 64'(s_sel), 64'd0);
    chk("rd_di", 64'(s_di), 64'd0);
    chk("rd_stb", 64'(s_stb), 64'd0);
    chk("rd_we", 64'(s_we), 64'd0);
    chk("rd_ackz", 64'(ack), 64'd0);
    step();
    sys_rst = 1'b0;
    #1;
    chk("rd_post_ack", 64'(ack), 64'd0);
    step();
    chk("rd_regrant_adr", 64'(s_adr), 64'(adr[0]));
    chk("rd_regrant_stb", 64'(s_stb), 64'd1);
    s_ack = 1'b1;
    #1;
    chk("rd_regrant_ack", 64'(ack), 64'b0001);
    step();
    s_ack = 1'b0;
    stb = 4'b0;
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
